// File: rtl/grid_mem_arbiter_pkg.sv
// rtl/grid_mem_arbiter_pkg.sv - shared tetris grid constants, piece codes and arbiter state type
//
// Purpose: one place for the playfield geometry, the 4-bit cell codes stored
// in the grid RAM, and the arbiter FSM state encoding.
// Ports: none (package).
package grid_mem_arbiter_pkg;

  localparam int GRID_COLS  = 12;
  localparam int GRID_ROWS  = 20;
  localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

  // Cell contents held in the low nibble of each grid RAM byte.
  typedef enum logic [3:0] {
    PC_AIR    = 4'd0,
    PC_I      = 4'd1,
    PC_O      = 4'd2,
    PC_T      = 4'd3,
    PC_S      = 4'd4,
    PC_Z      = 4'd5,
    PC_J      = 4'd6,
    PC_L      = 4'd7,
    PC_BORDER = 4'd8
  } piece_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  // Linear grid address of (row, col), row-major with GRID_COLS cells per row.
  function automatic logic [7:0] cell_addr(input int unsigned row, input int unsigned col);
    return 8'(row * GRID_COLS + col);
  endfunction

endpackage

// File: rtl/grid_mem_arbiter.sv
// rtl/grid_mem_arbiter.sv - time-slotted arbiter sharing one grid RAM between video and game logic
//
// Purpose: a free-running slot bit splits cycles into video (slot 0) and game
// (slot 1) slots. During active video the reader owns every slot-0 cycle;
// during blanking the game side may use any cycle. Game accesses run through
// a small IDLE/PEND/RDWAIT/ACK FSM, one request at a time.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   px_en                 - active-video enable (video owns slot 0 when high)
//   vid_addr / vid_data   - video read address / registered read data
//   game_req, game_we,
//   game_addr, game_wdata - game request, sampled only in IDLE
//   game_ack, game_err    - one-cycle completion pulse / out-of-range flag
//   game_rdata            - last game read result, held between reads
//   busy                  - high whenever the FSM is not IDLE
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata  - single-port synchronous RAM, 1-cycle read latency
module grid_mem_arbiter #(
  parameter int GRID_CELLS = grid_mem_arbiter_pkg::GRID_CELLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       px_en,
  input  logic [7:0] vid_addr,
  output logic [7:0] vid_data,
  input  logic       game_req,
  input  logic       game_we,
  input  logic [7:0] game_addr,
  input  logic [7:0] game_wdata,
  output logic       game_ack,
  output logic [7:0] game_rdata,
  output logic       game_err,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  import grid_mem_arbiter_pkg::*;

  localparam logic [8:0] CELLS_LIMIT = 9'(GRID_CELLS);

  arb_state_e state;
  logic       slot;
  logic       vid_rd;     // previous cycle was a video read; mem_rdata now holds its data
  logic       cap_we;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;

  logic vid_own;
  logic game_avail;
  logic cap_oor;
  logic game_go;

  assign vid_own    = !slot && px_en;
  assign game_avail = slot || !px_en;
  assign cap_oor    = {1'b0, cap_addr} >= CELLS_LIMIT;
  assign game_go    = (state == PEND) && game_avail && !cap_oor;
  assign busy       = (state != IDLE);

  // RAM port mux. Gated by reset so an access pending at reset never reaches
  // the RAM in the reset cycle itself.
  always_comb begin
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    if (!reset) begin
      if (vid_own) begin
        mem_addr = vid_addr;
      end else if (game_go) begin
        mem_addr  = cap_addr;
        mem_we    = cap_we;
        mem_wdata = cap_we ? cap_wdata : 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot       <= 1'b0;
      vid_rd     <= 1'b0;
      vid_data   <= 8'd0;
      state      <= IDLE;
      cap_we     <= 1'b0;
      cap_addr   <= 8'd0;
      cap_wdata  <= 8'd0;
      game_ack   <= 1'b0;
      game_err   <= 1'b0;
      game_rdata <= 8'd0;
    end else begin
      slot   <= ~slot;
      vid_rd <= vid_own;

      if (!px_en) begin
        vid_data <= 8'd0;
      end else if (vid_rd) begin
        vid_data <= mem_rdata;
      end

      case (state)
        IDLE: begin
          game_ack <= 1'b0;
          game_err <= 1'b0;
          if (game_req) begin
            cap_we    <= game_we;
            cap_addr  <= game_addr;
            cap_wdata <= game_wdata;
            state     <= PEND;
          end
        end
        PEND: begin
          // Out-of-range requests complete without touching the RAM and
          // leave game_rdata untouched.
          if (cap_oor) begin
            game_ack <= 1'b1;
            game_err <= 1'b1;
            state    <= ACK;
          end else if (game_avail) begin
            if (cap_we) begin
              game_ack <= 1'b1;
              state    <= ACK;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          game_rdata <= mem_rdata;
          game_ack   <= 1'b1;
          state      <= ACK;
        end
        ACK: begin
          game_ack <= 1'b0;
          game_err <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          game_ack <= 1'b0;
          game_err <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb/tb_grid_mem_arbiter.sv - directed self-checking bench for grid_mem_arbiter
module tb_grid_mem_arbiter;
  import grid_mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       px_en;
  logic [7:0] vid_addr;
  logic [7:0] vid_data;
  logic       game_req;
  logic       game_we;
  logic [7:0] game_addr;
  logic [7:0] game_wdata;
  logic       game_ack;
  logic [7:0] game_rdata;
  logic       game_err;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grid_mem_arbiter #(.GRID_CELLS(240)) dut (
    .clk        (clk),
    .reset      (reset),
    .px_en      (px_en),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_rdata (game_rdata),
    .game_err   (game_err),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Grid RAM model with a preload port used only while reset is held.
  logic [7:0] ram [256];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference slot phase and write monitors.
  logic tb_slot;
  int   we_count = 0;
  int   vid_we_viol = 0;

  always @(posedge clk) begin
    if (mem_we) we_count <= we_count + 1;
    if (mem_we && !tb_slot && px_en && !reset) vid_we_viol <= vid_we_viol + 1;
    tb_slot <= reset ? 1'b0 : ~tb_slot;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic align(input logic v);
    if (tb_slot != v) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic blank_read(input logic [7:0] addr, input logic [7:0] exp);
    game_req = 1'b1; game_we = 1'b0; game_addr = addr;
    tick();
    game_req = 1'b0;
    chk("blank_pend_addr", mem_addr, addr);
    chk("blank_pend_we", {7'd0, mem_we}, 8'd0);
    chk("blank_pend_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("blank_rdwait_ack", {7'd0, game_ack}, 8'd0);
    tick();
    chk("blank_ack", {7'd0, game_ack}, 8'd1);
    chk("blank_rdata", game_rdata, exp);
    chk("blank_err", {7'd0, game_err}, 8'd0);
    tick();
    chk("blank_idle_ack", {7'd0, game_ack}, 8'd0);
  endtask

  int acc;
  int acks;
  int wc;
  logic busy_c4;

  initial begin
    reset = 1'b1; px_en = 1'b1; vid_addr = cell_addr(1, 1);
    game_req = 1'b0; game_we = 1'b0; game_addr = 8'd0; game_wdata = 8'd0;
    bd_we = 1'b1; bd_addr = 8'd13; bd_data = 8'h03;
    tick();
    bd_addr = 8'd239; bd_data = 8'h08;
    tick();
    bd_addr = 8'd240; bd_data = 8'hAA;
    tick();
    bd_addr = 8'd30; bd_data = 8'h11;
    tick();
    bd_we = 1'b0;
    tick();

    // Reset state (video would own this cycle but reset gates the port).
    chk("rst_mem_addr", mem_addr, 8'd0);
    chk("rst_mem_we", {7'd0, mem_we}, 8'd0);
    chk("rst_vid_data", vid_data, 8'd0);
    chk("rst_ack", {7'd0, game_ack}, 8'd0);
    chk("rst_err", {7'd0, game_err}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_rdata", game_rdata, 8'd0);

    // Video-only reads of cell 13.
    reset = 1'b0;
    #1;
    chk("vid_slot0_addr", mem_addr, 8'd13);
    tick();
    chk("vid_slot1_addr", mem_addr, 8'd0);
    chk("vid_not_yet", vid_data, 8'd0);
    tick();
    chk("vid_data_first", vid_data, 8'h03);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("vid_data_steady", vid_data, 8'h03);
    end

    // Game write during active video, requested in a slot-0 cycle.
    align(1'b0);
    game_req = 1'b1; game_we = 1'b1; game_addr = 8'd25; game_wdata = 8'h07;
    tick();
    game_req = 1'b0;
    chk("wr_busy", {7'd0, busy}, 8'd1);
    chk("wr_mem_we", {7'd0, mem_we}, 8'd1);
    chk("wr_mem_addr", mem_addr, 8'd25);
    chk("wr_mem_wdata", mem_wdata, 8'h07);
    tick();
    chk("wr_ack", {7'd0, game_ack}, 8'd1);
    chk("wr_err", {7'd0, game_err}, 8'd0);
    chk("wr_ack_cycle_we", {7'd0, mem_we}, 8'd0);
    tick();
    chk("wr_ack_pulse", {7'd0, game_ack}, 8'd0);
    chk("wr_idle_busy", {7'd0, busy}, 8'd0);
    chk("wr_ram25", ram[25], 8'h07);

    // Read 25 back, requested in a slot-1 cycle: first PEND cycle is video-owned.
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'd25;
    tick();
    game_req = 1'b0;
    chk("rd_wait_we", {7'd0, mem_we}, 8'd0);
    chk("rd_wait_vid_addr", mem_addr, 8'd13);
    chk("rd_wait_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("rd_game_addr", mem_addr, 8'd25);
    tick();
    chk("rd_rdwait_ack", {7'd0, game_ack}, 8'd0);
    tick();
    chk("rd_ack", {7'd0, game_ack}, 8'd1);
    chk("rd_rdata", game_rdata, 8'h07);
    chk("rd_vid_kept", vid_data, 8'h03);
    tick();

    // px_en falls while a read waits in PEND: access is taken in the same cycle.
    align(1'b1);
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'd239;
    tick();
    game_req = 1'b0;
    chk("pxen_pend_vid", mem_addr, 8'd13);
    px_en = 1'b0;
    #1;
    chk("pxen_drop_addr", mem_addr, 8'd239);
    tick();
    tick();
    chk("pxen_ack", {7'd0, game_ack}, 8'd1);
    chk("pxen_rdata", game_rdata, 8'h08);
    chk("pxen_vid_zero", vid_data, 8'd0);
    tick();

    // Blanking reads, once with PEND on slot 0 and once on slot 1.
    align(1'b1);
    blank_read(8'd25, 8'h07);
    align(1'b0);
    blank_read(8'd239, 8'h08);

    // Out-of-range write and read.
    wc = we_count;
    game_req = 1'b1; game_we = 1'b1; game_addr = GRID_CELLS[7:0]; game_wdata = 8'h55;
    tick();
    game_req = 1'b0;
    chk("oor_wr_we", {7'd0, mem_we}, 8'd0);
    chk("oor_wr_addr", mem_addr, 8'd0);
    tick();
    chk("oor_wr_ack", {7'd0, game_ack}, 8'd1);
    chk("oor_wr_err", {7'd0, game_err}, 8'd1);
    tick();
    chk("oor_wr_err_clr", {7'd0, game_err}, 8'd0);
    chk("oor_wr_no_write", 8'(we_count - wc), 8'd0);
    chk("oor_ram240", ram[240], 8'hAA);
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'd255;
    tick();
    game_req = 1'b0;
    chk("oor_rd_addr", mem_addr, 8'd0);
    tick();
    chk("oor_rd_ack", {7'd0, game_ack}, 8'd1);
    chk("oor_rd_err", {7'd0, game_err}, 8'd1);
    chk("oor_rd_rdata", game_rdata, 8'h08);
    tick();

    // Request held high: exactly one access per acceptance.
    acc = 0; acks = 0; busy_c4 = 1'b1;
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'd239;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_addr == 8'd239) acc++;
      if (game_ack) acks++;
      if (i == 4) busy_c4 = busy;
    end
    game_req = 1'b0;
    chk("hold_accesses", 8'(acc), 8'd2);
    chk("hold_acks", 8'(acks), 8'd2);
    chk("hold_idle_gap", {7'd0, busy_c4}, 8'd0);
    tick();
    chk("hold_released", {7'd0, busy}, 8'd0);

    // Reset in PEND with a write that would issue this cycle.
    px_en = 1'b1;
    align(1'b0);
    wc = we_count;
    game_req = 1'b1; game_we = 1'b1; game_addr = 8'd30; game_wdata = 8'h5A;
    tick();
    game_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstop_mem_we", {7'd0, mem_we}, 8'd0);
    chk("rstop_mem_addr", mem_addr, 8'd0);
    tick();
    chk("rstop_busy", {7'd0, busy}, 8'd0);
    chk("rstop_ack", {7'd0, game_ack}, 8'd0);
    chk("rstop_err", {7'd0, game_err}, 8'd0);
    chk("rstop_vid", vid_data, 8'd0);
    chk("rstop_rdata", game_rdata, 8'd0);
    chk("rstop_we_after", {7'd0, mem_we}, 8'd0);
    reset = 1'b0;
    tick();
    chk("rstop_no_late_ack", {7'd0, game_ack}, 8'd0);
    chk("rstop_ram30", ram[30], 8'h11);
    chk("rstop_no_write", 8'(we_count - wc), 8'd0);

    chk("video_slot_we", 8'(vid_we_viol), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
